// File: rtl/imem_prefetch_buf.sv
// Sequential instruction prefetch buffer between the CPU fetch port and IMem.
// Fetches ahead into a small {addr, instr} FIFO so straight-line code hits
// with zero added latency. A non-sequential request flushes the FIFO and
// restarts fetching, draining any IMem request that is still in flight first.
module imem_prefetch_buf #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_cpu_addr,
  input  logic        i_cpu_valid,
  output logic        o_cpu_good,
  output logic [31:0] o_cpu_instr,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_valid,
  input  logic        i_mem_good,
  input  logic [31:0] i_mem_instr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_mem_addr;
  logic          r_mem_valid;
  logic [31:0]   r_exp_addr;
  logic [31:0]   r_restart_addr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fifo_addr  [DEPTH];
  logic [31:0]   r_fifo_instr [DEPTH];

  logic          w_empty;
  logic [31:0]   w_head_addr;
  logic [31:0]   w_head_instr;
  logic          w_hit;
  logic          w_wait;
  logic          w_miss;
  logic          w_mem_done;
  logic          w_enq;
  logic          w_pop;
  logic [CW-1:0] w_count_next;

  assign w_empty      = (r_count == '0);
  assign w_head_addr  = r_fifo_addr[r_rd_ptr];
  assign w_head_instr = r_fifo_instr[r_rd_ptr];
  assign w_mem_done   = r_mem_valid & i_mem_good;

  // Classify the CPU request: hit on the FIFO head, wait for the word already
  // being fetched, or miss (anything else, including a mismatching head).
  always_comb begin
    w_hit  = i_cpu_valid & ~w_empty & (w_head_addr == i_cpu_addr);
    w_wait = i_cpu_valid & w_empty &
             (((r_state == ST_FETCH) & (i_cpu_addr == r_exp_addr)) |
              ((r_state == ST_DRAIN) & (i_cpu_addr == r_restart_addr)));
    w_miss = i_cpu_valid & ~w_hit & ~w_wait;
  end

  // Only words fetched in FETCH are kept; a miss flushes, so its data is dropped.
  assign w_enq = (r_state == ST_FETCH) & w_mem_done & ~w_miss;
  assign w_pop = w_hit;

  // Occupancy after this edge, with pop and enqueue cancelling each other.
  always_comb begin
    w_count_next = r_count;
    if (w_enq & ~w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (~w_enq & w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  assign o_cpu_good  = w_hit;
  assign o_cpu_instr = w_hit ? w_head_instr : 32'h0;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_valid = r_mem_valid;

  // FIFO storage: written at the tail on each accepted IMem word.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_fifo_addr[r_wr_ptr]  <= r_exp_addr;
      r_fifo_instr[r_wr_ptr] <= i_mem_instr;
    end
  end

  // Control: FIFO pointers, fetch state machine and the IMem request register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_mem_addr     <= 32'h0;
      r_mem_valid    <= 1'b0;
      r_exp_addr     <= 32'h0;
      r_restart_addr <= 32'h0;
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
    end else if (w_miss) begin
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
      r_restart_addr <= i_cpu_addr;
      if (r_mem_valid & ~i_mem_good) begin
        // A request is still open and must be held stable until it completes.
        r_state <= ST_DRAIN;
      end else begin
        r_state     <= ST_FETCH;
        r_exp_addr  <= i_cpu_addr;
        r_mem_addr  <= i_cpu_addr;
        r_mem_valid <= 1'b1;
      end
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_count <= w_count_next;
      case (r_state)
        ST_FETCH: begin
          if (r_mem_valid) begin
            if (i_mem_good) begin
              r_exp_addr <= r_exp_addr + 32'd4;
              if (w_count_next < FULL) begin
                r_mem_addr <= r_exp_addr + 32'd4;
              end else begin
                r_mem_valid <= 1'b0;
              end
            end
          end else if (r_count < FULL) begin
            r_mem_addr  <= r_exp_addr;
            r_mem_valid <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_mem_done) begin
            r_mem_addr <= r_restart_addr;
            r_exp_addr <= r_restart_addr;
            r_state    <= ST_FETCH;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_prefetch_buf.sv
// Bench for imem_prefetch_buf: IMem responder with configurable latency,
// a per-cycle checker against a memory image and the IMem hold rules, and
// directed scenarios with hand-computed expectations.
module tb_imem_prefetch_buf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cpu_addr;
  logic        cpu_valid;
  logic        cpu_good;
  logic [31:0] cpu_instr;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic        mem_good;
  logic [31:0] mem_instr;

  int          ncmp = 0;
  int          nfail = 0;
  int          lat = 1;
  bit          force_good = 1'b0;
  int          age = 0;
  logic [31:0] req_log [$];
  logic [31:0] got;

  always #5 clk = ~clk;

  imem_prefetch_buf #(.DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_valid (cpu_valid),
    .o_cpu_good  (cpu_good),
    .o_cpu_instr (cpu_instr),
    .o_mem_addr  (mem_addr),
    .o_mem_valid (mem_valid),
    .i_mem_good  (mem_good),
    .i_mem_instr (mem_instr)
  );

  // Memory image: the word stored at each byte address.
  function automatic logic [31:0] img(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // IMem model: answers each request 'lat' cycles after it is first presented.
  initial begin
    mem_good  = 1'b0;
    mem_instr = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !mem_valid) begin
        age = 0;
      end else if (age == 0 || mem_good) begin
        age = 1;
        req_log.push_back(mem_addr);
      end else begin
        age++;
      end
      mem_good  = force_good || (mem_valid && !rst && age > lat);
      mem_instr = (mem_valid && !rst && age > lat) ? img(mem_addr) : 32'hBADBAD00;
    end
  end

  // Per-cycle checker: delivered words must match the image, cpu_instr is 0
  // when idle, and an open IMem request stays stable until it completes.
  initial begin
    bit          prev_hold;
    logic [31:0] prev_addr;
    prev_hold = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(posedge clk);
      #4;
      if (!rst) begin
        if (cpu_good) begin
          check("good_needs_valid", 32'(cpu_valid), 32'd1);
          check("instr_vs_image", cpu_instr, img(cpu_addr));
        end else begin
          check("instr_zero_idle", cpu_instr, 32'h0);
        end
        if (prev_hold) begin
          check("mem_valid_hold", 32'(mem_valid), 32'd1);
          check("mem_addr_hold", mem_addr, prev_addr);
        end
        prev_hold = mem_valid && !mem_good;
        prev_addr = mem_addr;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_valid = 1'b0;
    cpu_addr = 32'h0;
    force_good = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    req_log.delete();
    cyc();
  endtask

  // Single-cycle request: a miss that starts prefetch without consuming.
  task automatic pulse(input logic [31:0] a);
    cpu_valid = 1'b1;
    cpu_addr = a;
    cyc();
    cpu_valid = 1'b0;
  endtask

  // Hold a request until cpu_good; exp_lat < 0 skips the latency check.
  task automatic req(input logic [31:0] a, input int exp_lat, input string name,
                     output logic [31:0] instr);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    instr = 32'h0;
    cpu_valid = 1'b1;
    cpu_addr = a;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (cpu_good) begin
        seen = 1'b1;
        instr = cpu_instr;
        break;
      end
      @(posedge clk);
      #2;
      n++;
    end
    if (!seen) begin
      ncmp++;
      nfail++;
      $display("FAIL %s: no cpu_good within 40 cycles for addr %h", name, a);
    end else begin
      $display("req %s addr=%h latency=%0d instr=%h", name, a, n, instr);
      if (exp_lat >= 0) check(name, 32'(n), 32'(exp_lat));
    end
    @(posedge clk);
    #2;
    cpu_valid = 1'b0;
  endtask

  task automatic wait_reqs(input int n, input string name);
    for (int k = 0; k < 200; k++) begin
      if (req_log.size() >= n) break;
      cyc();
    end
    check(name, 32'(req_log.size()), 32'(n));
  endtask

  task automatic check_log(input int idx, input logic [31:0] exp, input string name);
    if (idx < req_log.size()) begin
      check(name, req_log[idx], exp);
    end else begin
      ncmp++;
      nfail++;
      $display("FAIL %s: request %0d missing, expected %h", name, idx, exp);
    end
  endtask

  initial begin
    int n200;
    cpu_valid = 1'b0;
    cpu_addr = 32'h0;

    // Reset state
    do_reset();
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_cpu_good", 32'(cpu_good), 32'd0);
    check("rst_cpu_instr", cpu_instr, 32'h0);

    // Cold start with 1-cycle IMem, then same-cycle sequential hits
    lat = 1;
    req(32'h0, 3, "cold0_lat", got);
    check("cold0_word", got, 32'h5A5A5A5A);
    wait_cycles(15);
    check_log(0, 32'h0, "cold_req0");
    check_log(1, 32'h4, "cold_req1");
    check_log(2, 32'h8, "cold_req2");
    check_log(3, 32'hC, "cold_req3");
    check("cold_full_stop", 32'(mem_valid), 32'd0);
    req(32'h4, 0, "hit4_lat", got);
    check("hit4_word", got, 32'h2287BC9E);
    req(32'h8, 0, "hit8_lat", got);
    req(32'hC, 0, "hitC_lat", got);

    // Branch while 0x1C is in flight with 3-cycle IMem
    do_reset();
    lat = 3;
    pulse(32'h10);
    wait_reqs(4, "br_nreq");
    check_log(3, 32'h1C, "br_inflight");
    cpu_valid = 1'b1;
    cpu_addr = 32'h100;
    cyc();
    check("br_drain_addr", mem_addr, 32'h1C);
    check("br_drain_valid", 32'(mem_valid), 32'd1);
    req(32'h100, -1, "br_target", got);
    check("br_target_word", got, img(32'h100));
    check_log(4, 32'h100, "br_refetch");

    // Full stall from 0x40 with the CPU idle
    do_reset();
    lat = 1;
    pulse(32'h40);
    wait_cycles(20);
    check("stall_nreq", 32'(req_log.size()), 32'd4);
    check_log(0, 32'h40, "stall_req0");
    check_log(3, 32'h4C, "stall_req3");
    check("stall_idle", 32'(mem_valid), 32'd0);
    req(32'h40, 0, "stall_hit", got);
    wait_cycles(10);
    check("stall_nreq_after", 32'(req_log.size()), 32'd5);
    check_log(4, 32'h50, "stall_refill");
    check("stall_idle_after", 32'(mem_valid), 32'd0);

    // Address wrap
    do_reset();
    lat = 1;
    req(32'hFFFFFFF8, 3, "wrap_lat", got);
    wait_cycles(15);
    check_log(0, 32'hFFFFFFF8, "wrap_req0");
    check_log(1, 32'hFFFFFFFC, "wrap_req1");
    check_log(2, 32'h00000000, "wrap_req2");
    req(32'hFFFFFFFC, 0, "wrap_hitFC", got);
    check("wrap_wordFC", got, 32'hDD784366);
    req(32'h0, 0, "wrap_hit0", got);
    check("wrap_word0", got, 32'h5A5A5A5A);

    // Asynchronous reset with two words buffered and 0x88 outstanding
    do_reset();
    lat = 1;
    pulse(32'h80);
    wait_reqs(3, "mid_nreq");
    check_log(2, 32'h88, "mid_inflight");
    cpu_valid = 1'b1;
    cpu_addr = 32'h80;
    #1;
    check("mid_pre_hit", 32'(cpu_good), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
    check("mid_rst_cpu_good", 32'(cpu_good), 32'd0);
    cpu_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    req_log.delete();
    force_good = 1'b1;
    cyc();
    force_good = 1'b0;
    cyc();
    cyc();
    check("mid_no_req", 32'(mem_valid), 32'd0);
    req(32'h0, 3, "mid_cold_lat", got);
    check_log(0, 32'h0, "mid_cold_req");

    // Re-miss while draining: only the latest target is fetched
    do_reset();
    lat = 3;
    pulse(32'h20);
    pulse(32'h200);
    req(32'h300, -1, "remiss", got);
    check_log(0, 32'h20, "remiss_req0");
    check_log(1, 32'h300, "remiss_req1");
    n200 = 0;
    foreach (req_log[i]) if (req_log[i] == 32'h200) n200++;
    check("remiss_no200", 32'(n200), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
